// File: rtl/lab3_mem_test_mem_responder_if.sv
// Memory-side val/rdy channel between a cache (master) and the memory responder (slave).
// Request {type 3, opaque, addr 32, len 4, data 128}; response {type 3, opaque, test 2, len 4, data 128}.
interface lab3_mem_test_mem_responder_if #(
   parameter int unsigned p_opaque_nbits = 8
);
   localparam int unsigned REQ_NBITS  = 3 + p_opaque_nbits + 32 + 4 + 128;
   localparam int unsigned RESP_NBITS = 3 + p_opaque_nbits + 2 + 4 + 128;

   logic [REQ_NBITS-1:0]  memreq_msg;
   logic                  memreq_val;
   logic                  memreq_rdy;
   logic [RESP_NBITS-1:0] memresp_msg;
   logic                  memresp_val;
   logic                  memresp_rdy;

   modport master (
      output memreq_msg, memreq_val, memresp_rdy,
      input  memreq_rdy, memresp_msg, memresp_val
   );

   modport slave (
      input  memreq_msg, memreq_val, memresp_rdy,
      output memreq_rdy, memresp_msg, memresp_val
   );
endinterface

// File: rtl/lab3_mem_test_mem_responder.sv
// Line-granular backing-store model: one request at a time, response after p_latency
// extra cycles; writes commit on the accept edge, reads snapshot the line at accept.
module lab3_mem_test_mem_responder #(
   parameter int unsigned p_mem_nlines   = 64,
   parameter int unsigned p_latency      = 2,
   parameter int unsigned p_opaque_nbits = 8
) (
   input logic                          clk,
   input logic                          reset,
   lab3_mem_test_mem_responder_if.slave mem
);
   localparam int unsigned abw = 32;
   localparam int unsigned clw = 128;
   localparam int unsigned o   = p_opaque_nbits;
   localparam int unsigned IW  = $clog2(p_mem_nlines);
   localparam logic [3:0]  LAT_INIT = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, DELAY, RESP} state_e;

   state_e               state_q;
   logic [3:0]           cnt_q;
   logic                 rdy_q;
   logic                 val_q;
   logic [3+o+2+4+clw-1:0] resp_q;
   logic [clw-1:0]       mem_q [p_mem_nlines];

   logic [2:0]     req_type;
   logic [o-1:0]   req_opaque;
   logic [abw-1:0] req_addr;
   logic [3:0]     req_len;
   logic [clw-1:0] req_data;
   logic [IW-1:0]  idx;
   logic [clw-1:0] line_rd;
   logic [clw-1:0] line_wr;
   logic [clw-1:0] rdata;
   logic [clw-1:0] resp_data;
   logic           is_wr;
   logic           req_rdy;
   logic           accept;
   int unsigned    off;
   int unsigned    nbytes;

   assign {req_type, req_opaque, req_addr, req_len, req_data} = mem.memreq_msg;
   assign idx     = req_addr[4 +: IW];
   assign is_wr   = (req_type == 3'd1) || (req_type == 3'd2);
   // rdy_q resets high so the port is ready the instant reset releases; gate it while in reset.
   assign req_rdy = rdy_q & reset;
   assign accept  = mem.memreq_val && req_rdy;
   assign line_rd = mem_q[idx];

   assign mem.memreq_rdy  = req_rdy;
   assign mem.memresp_val = val_q;
   assign mem.memresp_msg = resp_q;

   always_comb begin
      off     = {28'd0, req_addr[3:0]};
      nbytes  = (req_len == 4'd0) ? 32'd16 : {28'd0, req_len};
      line_wr = line_rd;
      rdata   = '0;
      // Byte lanes past 15 are dropped rather than wrapping into the next line.
      for (int unsigned b = 0; b < 16; b++) begin
         if (b >= off && b < off + nbytes)
            line_wr[8*b +: 8] = req_data[8*(b-off) +: 8];
         if (b < nbytes && b + off < 16)
            rdata[8*b +: 8] = line_rd[8*(b+off) +: 8];
      end
      resp_data = is_wr ? '0 : rdata;
   end

   always_ff @(posedge clk) begin
      if (accept && is_wr)
         mem_q[idx] <= line_wr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdy_q   <= 1'b1;
         val_q   <= 1'b0;
         resp_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  resp_q <= {req_type, req_opaque, 2'b00, req_len, resp_data};
                  rdy_q  <= 1'b0;
                  if (p_latency > 0) begin
                     state_q <= DELAY;
                     cnt_q   <= LAT_INIT;
                  end else begin
                     state_q <= RESP;
                     val_q   <= 1'b1;
                  end
               end
            end
            DELAY: begin
               if (cnt_q == '0) begin
                  state_q <= RESP;
                  val_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (mem.memresp_rdy) begin
                  state_q <= IDLE;
                  val_q   <= 1'b0;
                  rdy_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lab3_mem_test_mem_responder.sv
// Scoreboard bench: two responders (latency 2 and latency 0) driven by directed and random
// traffic, checked against a byte-array memory model and per-response latency/stability rules.
module tb_lab3_mem_test_mem_responder;
   localparam int unsigned NL   = 64;
   localparam int unsigned O    = 8;
   localparam int unsigned LAT0 = 2;
   localparam int unsigned LAT1 = 0;

   typedef struct {
      logic [144:0] msg;
      int unsigned  acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   lab3_mem_test_mem_responder_if #(.p_opaque_nbits(O)) ifc0 ();
   lab3_mem_test_mem_responder_if #(.p_opaque_nbits(O)) ifc1 ();

   lab3_mem_test_mem_responder #(
      .p_mem_nlines(NL), .p_latency(LAT0), .p_opaque_nbits(O)
   ) u_dut0 (
      .clk(clk), .reset(rst0), .mem(ifc0.slave)
   );

   lab3_mem_test_mem_responder #(
      .p_mem_nlines(NL), .p_latency(LAT1), .p_opaque_nbits(O)
   ) u_dut1 (
      .clk(clk), .reset(rst1), .mem(ifc1.slave)
   );

   exp_t        q0[$];
   exp_t        q1[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned bp0 = 0;
   byte unsigned mdl [2][NL][16];

   task automatic chk(string name, logic [144:0] act, logic [144:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: a line is 16 independent bytes; writes touch bytes off..off+n-1 below 16.
   function automatic logic [127:0] model(int unsigned d, logic [2:0] t, logic [31:0] addr,
                                          logic [3:0] len, logic [127:0] data);
      int unsigned line = (addr / 16) % NL;
      int unsigned off  = addr % 16;
      int unsigned n    = len;
      logic [127:0] r   = '0;
      if (len == 4'd0) n = 16;
      for (int unsigned k = 0; k < n; k++) begin
         if (off + k < 16) begin
            if (t == 3'd1 || t == 3'd2) mdl[d][line][off+k] = data[8*k +: 8];
            else r[8*k +: 8] = mdl[d][line][off+k];
         end
      end
      return r;
   endfunction

   task automatic send0(logic [2:0] t, logic [31:0] addr, logic [3:0] len,
                        logic [127:0] data, logic [7:0] opq);
      exp_t e;
      int unsigned g = 0;
      @(negedge clk);
      ifc0.memreq_msg = {t, opq, addr, len, data};
      ifc0.memreq_val = 1'b1;
      while (!ifc0.memreq_rdy && g < 200) begin @(negedge clk); g++; end
      if (!ifc0.memreq_rdy) begin
         checks++; errors++;
         $display("FAIL req_timeout0: memreq_rdy stayed 0 expected 1");
         ifc0.memreq_val = 1'b0;
         return;
      end
      e.msg = {t, opq, 2'b00, len, model(0, t, addr, len, data)};
      e.acc = cyc + 1;
      q0.push_back(e);
      @(posedge clk);
      #1 ifc0.memreq_val = 1'b0;
   endtask

   task automatic send1(logic [2:0] t, logic [31:0] addr, logic [3:0] len,
                        logic [127:0] data, logic [7:0] opq);
      exp_t e;
      int unsigned g = 0;
      @(negedge clk);
      ifc1.memreq_msg = {t, opq, addr, len, data};
      ifc1.memreq_val = 1'b1;
      while (!ifc1.memreq_rdy && g < 200) begin @(negedge clk); g++; end
      if (!ifc1.memreq_rdy) begin
         checks++; errors++;
         $display("FAIL req_timeout1: memreq_rdy stayed 0 expected 1");
         ifc1.memreq_val = 1'b0;
         return;
      end
      e.msg = {t, opq, 2'b00, len, model(1, t, addr, len, data)};
      e.acc = cyc + 1;
      q1.push_back(e);
      @(posedge clk);
      #1 ifc1.memreq_val = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [31:0] line_addr(int unsigned l);
      logic [31:0] a = $urandom;
      a[9:0] = '0;
      return a | (l << 4);
   endfunction

   // Monitors: pop on the rising edge of memresp_val, then enforce hold/stability until handshake.
   initial begin : mon0
      bit busy = 0;
      bit done = 0;
      logic [144:0] held;
      exp_t e;
      ifc0.memresp_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst0) begin
            busy = 0; done = 0; ifc0.memresp_rdy = 1'b0;
            continue;
         end
         if (done) begin
            chk("idle_after_hs0", 145'({ifc0.memresp_val, ifc0.memreq_rdy}), 145'(2'b01));
            done = 0;
         end
         if (ifc0.memresp_val) begin
            if (!busy) begin
               busy = 1;
               held = ifc0.memresp_msg;
               if (q0.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_resp0: got %h expected none", held);
               end else begin
                  e = q0.pop_front();
                  chk("resp_msg0", held, e.msg);
                  chk("latency0", 145'(cyc - e.acc), 145'(LAT0));
               end
            end else begin
               chk("resp_stable0", ifc0.memresp_msg, held);
            end
            chk("req_rdy_low0", 145'(ifc0.memreq_rdy), 145'(0));
            if (bp0 > 0) begin
               bp0--;
               ifc0.memresp_rdy = 1'b0;
            end else begin
               ifc0.memresp_rdy = ($urandom_range(0, 3) != 0);
            end
            if (ifc0.memresp_rdy) begin busy = 0; done = 1; end
         end else begin
            if (busy) begin
               checks++; errors++;
               $display("FAIL val_dropped0: memresp_val got 0 expected 1");
               busy = 0;
            end
            ifc0.memresp_rdy = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin : mon1
      bit busy = 0;
      bit done = 0;
      logic [144:0] held;
      exp_t e;
      ifc1.memresp_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst1) begin
            busy = 0; done = 0; ifc1.memresp_rdy = 1'b0;
            continue;
         end
         if (done) begin
            chk("idle_after_hs1", 145'({ifc1.memresp_val, ifc1.memreq_rdy}), 145'(2'b01));
            done = 0;
         end
         if (ifc1.memresp_val) begin
            if (!busy) begin
               busy = 1;
               held = ifc1.memresp_msg;
               if (q1.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_resp1: got %h expected none", held);
               end else begin
                  e = q1.pop_front();
                  chk("resp_msg1", held, e.msg);
                  chk("latency1", 145'(cyc - e.acc), 145'(LAT1));
               end
            end else begin
               chk("resp_stable1", ifc1.memresp_msg, held);
            end
            chk("req_rdy_low1", 145'(ifc1.memreq_rdy), 145'(0));
            ifc1.memresp_rdy = ($urandom_range(0, 2) != 0);
            if (ifc1.memresp_rdy) begin busy = 0; done = 1; end
         end else begin
            if (busy) begin
               checks++; errors++;
               $display("FAIL val_dropped1: memresp_val got 0 expected 1");
               busy = 0;
            end
            ifc1.memresp_rdy = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic run0();
      int unsigned g;
      for (int unsigned l = 0; l < NL; l++) send0(3'd2, line_addr(l), 4'd0, rnd128(), 8'($urandom));
      send0(3'd2, 32'h40, 4'd0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 8'h11);
      send0(3'd0, 32'h40, 4'd0, '0, 8'h12);
      send0(3'd1, 32'h44, 4'd2, 128'h0000AABB, 8'h21);
      send0(3'd0, 32'h40, 4'd0, '0, 8'h22);
      send0(3'd1, 32'h4C, 4'd4, 128'h44332211, 8'h23);
      send0(3'd0, 32'h4C, 4'd4, '0, 8'h24);
      // Backpressure: start from idle so the 5-cycle hold applies to this response.
      g = 0;
      while (!ifc0.memreq_rdy && g < 200) begin @(negedge clk); g++; end
      bp0 = 5;
      send0(3'd0, 32'h80, 4'd0, '0, 8'h31);
      // Reset while in DELAY after a committed write; the write must survive.
      send0(3'd1, 32'h90, 4'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'h41);
      @(negedge clk);
      rst0 = 1'b0;
      #1;
      chk("rst_mid_val", 145'(ifc0.memresp_val), 145'(0));
      chk("rst_mid_rdy", 145'(ifc0.memreq_rdy), 145'(0));
      chk("rst_mid_msg", 145'(ifc0.memresp_msg), 145'(0));
      q0.delete();
      repeat (2) @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      chk("rst_mid_rdy_after", 145'(ifc0.memreq_rdy), 145'(1));
      repeat (10) @(negedge clk);
      send0(3'd0, 32'h90, 4'd0, '0, 8'h42);
      for (int unsigned i = 0; i < 200; i++)
         send0(3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)), rnd128(), 8'($urandom));
   endtask

   task automatic run1();
      for (int unsigned l = 0; l < NL; l++) send1(3'd2, line_addr(l), 4'd0, rnd128(), 8'($urandom));
      send1(3'd2, 32'h40, 4'd0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 8'h51);
      send1(3'd0, 32'h40, 4'd0, '0, 8'h52);
      send1(3'd0, 32'h1040, 4'd0, '0, 8'h53);
      for (int unsigned i = 0; i < 150; i++)
         send1(3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)), rnd128(), 8'($urandom));
   endtask

   initial begin : main
      rst0 = 1'b0;
      rst1 = 1'b0;
      ifc0.memreq_val = 1'b0;
      ifc0.memreq_msg = '0;
      ifc1.memreq_val = 1'b0;
      ifc1.memreq_msg = '0;
      #1;
      chk("rst_rdy0", 145'(ifc0.memreq_rdy), 145'(0));
      chk("rst_val0", 145'(ifc0.memresp_val), 145'(0));
      chk("rst_msg0", 145'(ifc0.memresp_msg), 145'(0));
      chk("rst_rdy1", 145'(ifc1.memreq_rdy), 145'(0));
      chk("rst_val1", 145'(ifc1.memresp_val), 145'(0));
      repeat (3) @(negedge clk);
      rst0 = 1'b1;
      rst1 = 1'b1;
      #1;
      chk("rdy_after_rst0", 145'(ifc0.memreq_rdy), 145'(1));
      chk("rdy_after_rst1", 145'(ifc1.memreq_rdy), 145'(1));
      fork
         run0();
         run1();
      join
      for (int i = 0; i < 500 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      chk("drain", 145'(q0.size() + q1.size()), 145'(0));
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached expected completion");
      $fatal(1, "watchdog");
   end
endmodule
